// File: rtl/enc_4to2_keycap.sv
// enc_4to2_keycap: debounced 4-line priority encoder feeding a 4-entry valid/ready FIFO
module enc_4to2_keycap #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] in,
    output logic [1:0] out_code,
    output logic       out_multi,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [2:0] level,
    output logic       overflow
);
    typedef enum logic [1:0] {IDLE, DEBOUNCE, HOLD} state_t;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    state_t state_q, state_d;
    logic [3:0] cand_q, cand_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0] mem_q [4];
    logic [2:0] mem_d [4];
    logic [1:0] wr_q, wr_d, rd_q, rd_d;
    logic [2:0] level_q, level_d;
    logic ovf_q, ovf_d;
    logic push, pop, accept;
    logic [2:0] entry;
    assign entry = {$countones(cand_q) > 1,
                    cand_q[3] ? 2'b11 : cand_q[2] ? 2'b10 : cand_q[1] ? 2'b01 : 2'b00};
    assign push = state_q == DEBOUNCE && in == cand_q && cnt_q == LAST;
    assign pop = level_q != 3'd0 && out_ready;
    assign accept = push && (level_q != 3'd4 || pop);
    always_comb begin
        state_d = state_q;
        cand_d = cand_q;
        cnt_d = cnt_q;
        if (state_q == IDLE && in != 4'd0) begin
            state_d = DEBOUNCE;
            cand_d = in;
            cnt_d = '0;
        end else if (state_q == DEBOUNCE) begin
            if (in == 4'd0) state_d = IDLE;
            else if (in != cand_q) begin
                cand_d = in;
                cnt_d = '0;
            end else if (cnt_q == LAST) state_d = HOLD;
            else cnt_d = cnt_q + 1'b1;
        end else if (state_q == HOLD && in == 4'd0) state_d = IDLE;
        mem_d = mem_q;
        if (accept) mem_d[wr_q] = entry;
        wr_d = accept ? wr_q + 2'd1 : wr_q;
        rd_d = pop ? rd_q + 2'd1 : rd_q;
        level_d = level_q + 3'(accept) - 3'(pop);
        ovf_d = ovf_q | (push & ~accept);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cand_q <= '0;
            cnt_q <= '0;
            mem_q <= '{default: '0};
            wr_q <= '0;
            rd_q <= '0;
            level_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cand_q <= cand_d;
            cnt_q <= cnt_d;
            mem_q <= mem_d;
            wr_q <= wr_d;
            rd_q <= rd_d;
            level_q <= level_d;
            ovf_q <= ovf_d;
        end
    end
    assign out_valid = level_q != 3'd0;
    assign out_code = out_valid ? mem_q[rd_q][1:0] : 2'b00;
    assign out_multi = out_valid & mem_q[rd_q][2];
    assign level = level_q;
    assign overflow = ovf_q;
endmodule

// File: tb/tb_enc_4to2_keycap.sv
// tb_enc_4to2_keycap: directed-vector bench for the debounced keycap encoder
module tb_enc_4to2_keycap;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [3:0] in = 4'd0;
    logic out_ready = 1'b0;
    logic [1:0] out_code;
    logic out_multi, out_valid, overflow;
    logic [2:0] level;
    int errors = 0;
    int checks = 0;
    enc_4to2_keycap #(.DEBOUNCE_CYCLES(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .in(in), .out_code(out_code), .out_multi(out_multi),
        .out_valid(out_valid), .out_ready(out_ready), .level(level), .overflow(overflow)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic press(input logic [3:0] v);
        in = v;
        repeat (5) step();
        in = 4'd0;
        step();
    endtask
    initial begin
        step();
        step();
        rst = 1'b0;
        check("rst_valid", 8'(out_valid), 8'd0);
        check("rst_code", 8'(out_code), 8'd0);
        check("rst_multi", 8'(out_multi), 8'd0);
        check("rst_level", 8'(level), 8'd0);
        check("rst_ovf", 8'(overflow), 8'd0);
        in = 4'b0100;
        for (int i = 1; i <= 6; i++) begin
            step();
            if (i == 4) check("press_valid_e4", 8'(out_valid), 8'd0);
            if (i == 5) check("press_valid_e5", 8'(out_valid), 8'd1);
        end
        in = 4'd0;
        step();
        check("press_code", 8'(out_code), 8'd2);
        check("press_multi", 8'(out_multi), 8'd0);
        check("press_level", 8'(level), 8'd1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("press_drain", 8'(level), 8'd0);
        in = 4'b0010;
        repeat (3) step();
        in = 4'd0;
        step();
        check("glitch_level", 8'(level), 8'd0);
        in = 4'b0001;
        repeat (2) step();
        in = 4'b0100;
        repeat (5) step();
        in = 4'd0;
        step();
        check("restart_level", 8'(level), 8'd1);
        check("restart_code", 8'(out_code), 8'd2);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        press(4'b1011);
        check("multi_code", 8'(out_code), 8'd3);
        check("multi_flag", 8'(out_multi), 8'd1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("multi_drain", 8'(level), 8'd0);
        press(4'b0001);
        press(4'b0010);
        press(4'b0100);
        press(4'b1000);
        check("fill_level", 8'(level), 8'd4);
        check("fill_ovf0", 8'(overflow), 8'd0);
        press(4'b0011);
        check("ovf_level", 8'(level), 8'd4);
        check("ovf_flag", 8'(overflow), 8'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("drain_code%0d", i), 8'(out_code), 8'(i));
            check($sformatf("drain_multi%0d", i), 8'(out_multi), 8'd0);
            step();
        end
        out_ready = 1'b0;
        check("drain_level", 8'(level), 8'd0);
        press(4'b0001);
        press(4'b0010);
        press(4'b0100);
        press(4'b1000);
        in = 4'b1001;
        repeat (4) step();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("fullpp_level", 8'(level), 8'd4);
        check("fullpp_head", 8'(out_code), 8'd1);
        in = 4'd0;
        step();
        out_ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            check($sformatf("fullpp_code%0d", i), 8'(out_code), 8'(i));
            step();
        end
        check("fullpp_last_code", 8'(out_code), 8'd3);
        check("fullpp_last_multi", 8'(out_multi), 8'd1);
        step();
        out_ready = 1'b0;
        check("fullpp_empty", 8'(level), 8'd0);
        press(4'b0100);
        press(4'b0010);
        check("bp_level2", 8'(level), 8'd2);
        check("bp_head2", 8'(out_code), 8'd2);
        out_ready = 1'b1;
        step();
        check("bp_level1a", 8'(level), 8'd1);
        check("bp_head1", 8'(out_code), 8'd1);
        out_ready = 1'b0;
        step();
        check("bp_level1b", 8'(level), 8'd1);
        check("bp_stable", 8'(out_code), 8'd1);
        out_ready = 1'b1;
        step();
        check("bp_level0", 8'(level), 8'd0);
        step();
        check("bp_empty_ready", 8'(level), 8'd0);
        check("bp_empty_valid", 8'(out_valid), 8'd0);
        out_ready = 1'b0;
        press(4'b0001);
        press(4'b0010);
        press(4'b0100);
        check("rstmid_level3", 8'(level), 8'd3);
        in = 4'b1000;
        repeat (2) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rstmid_level", 8'(level), 8'd0);
        check("rstmid_valid", 8'(out_valid), 8'd0);
        check("rstmid_ovf", 8'(overflow), 8'd0);
        repeat (4) step();
        check("rstmid_e4", 8'(out_valid), 8'd0);
        step();
        check("rstmid_e5", 8'(out_valid), 8'd1);
        check("rstmid_code", 8'(out_code), 8'd3);
        in = 4'd0;
        step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/enc_4to2_keycap.md
Name: enc_4to2_keycap

Overview:
- Sequential counterpart of the team's 2-to-4 decoders: captures a 4-line input vector (buttons or one-hot select lines) and debounces it.
- Priority-encodes each accepted press into a 2-bit code plus a multi-hot flag.
- Queues results in a 4-entry FIFO drained over a valid/ready handshake.
- Sits between raw board inputs and the consumer logic that previously fed a decoder directly.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive stable samples (after the first) required to accept a press; legal range 1..255.
- CNT_W, 8, debounce counter width; must hold DEBOUNCE_CYCLES-1.

Ports:
- clk  input  1  single clock; all logic is rising-edge.
- rst  input  1  synchronous, active-high reset.
- in  input  4  raw request lines, synchronous to clk; bit 3 has the highest priority.
- out_code  output  2  encoded index of the FIFO head entry; 2'b00 when empty.
- out_multi  output  1  head entry had more than one bit set; 0 when empty.
- out_valid  output  1  FIFO non-empty.
- out_ready  input  1  consumer accepts the head entry on a cycle with out_valid && out_ready.
- level  output  3  FIFO occupancy, 0..4.
- overflow  output  1  sticky: a press was dropped because the FIFO was full.

Behaviour:
- Reset (rst=1 at a clk edge):
  - FSM enters IDLE; FIFO is emptied; debounce counter and candidate are cleared.
  - Outputs: out_valid=0, out_code=0, out_multi=0, level=0, overflow=0.
  - Reset mid-debounce discards the candidate. Reset with entries queued discards all entries.
- FSM, states IDLE, DEBOUNCE, HOLD:
  - IDLE: if in!=0, latch cand<=in, cnt<=0, go to DEBOUNCE. Otherwise stay.
  - DEBOUNCE, in==0: go to IDLE.
  - DEBOUNCE, in!=0 and in!=cand: cand<=in, cnt<=0, stay in DEBOUNCE (restart).
  - DEBOUNCE, in==cand and cnt<DEBOUNCE_CYCLES-1: cnt<=cnt+1.
  - DEBOUNCE, in==cand and cnt==DEBOUNCE_CYCLES-1: push {multi(cand), enc(cand)}, go to HOLD.
  - HOLD: stay until in==0, then go to IDLE. Exactly one entry per press; changes while held are ignored.
- Encoding (highest set bit wins):
  - in[3] gives 2'b11; else in[2] gives 2'b10; else in[1] gives 2'b01; else in[0] gives 2'b00.
  - multi=1 when popcount(cand)>=2.
- Latency:
  - First nonzero sample at edge k: the push happens at edge k+DEBOUNCE_CYCLES, and out_valid is high after that edge if the FIFO was empty.
  - No combinational path from in to any output.
- FIFO (4 entries, 3-bit entries, 2-bit read/write pointers with wrap-around, level counter 0..4):
  - Pop occurs on an edge with out_valid && out_ready.
  - out_code and out_multi reflect the head entry combinationally from the FIFO storage and are stable while out_valid && !out_ready.
  - Push when level==4 without a simultaneous pop: the entry is dropped, overflow<=1, and the FSM still moves to HOLD.
  - Push and pop on the same edge when full: both take effect, no drop, level stays 4.
  - Push and pop on the same edge when level is 1..3: level is unchanged.
  - Push into an empty FIFO with out_ready=1: the entry appears the next cycle. There is no bypass; the pop happens on a later edge.
  - out_ready while empty is ignored; level never underflows.
- overflow clears only on rst.

Test Plan:
- Press and release (DEBOUNCE_CYCLES=4): reset, in=4'b0100 held 6 cycles, then 0, out_ready=0 -> out_valid rises after the 4th edge following the first sample; out_code=2'b10, out_multi=0, level=1. No second entry while held.
- Glitch rejection: in=4'b0010 for 3 cycles, then 0 -> no push, level=0. Next, in=0001 for 2 cycles then 0100 for 5 -> a single entry with code 2'b10.
- Multi-hot priority: in=4'b1011 stable for 5 cycles -> out_code=2'b11, out_multi=1.
- FIFO fill and overflow: 5 separate presses with out_ready=0 -> level=4, overflow=1, and entries 1-4 drain in order once out_ready=1. Then a 6th press with out_ready held 1 through the push edge while full -> no drop.
- Backpressure: with 2 entries queued, toggle out_ready 1,0,1 -> exactly 2 pops, out_code stable during the 0 cycle, level goes 2,1,1,0. out_ready=1 while empty leaves level=0.
- Reset mid-operation: assert rst while in DEBOUNCE with 3 entries queued -> the next cycle shows level=0, out_valid=0, overflow=0, and a held input restarts debounce from IDLE.
